// File: rtl/count_bit_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_bit_seq_pkg
// Description : Shared types and widths for the sequential CLO/CLZ unit:
//               controller state encoding and count widths.
// Revision    : 1.0 - initial release
// ============================================================================
package count_bit_seq_pkg;

    // Controller states of the shared byte scanner
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Accumulator width: holds 0..32
    localparam int COUNT_W    = 6;
    // Per-byte count width: holds 0..8
    localparam int BYTE_CNT_W = 4;

endpackage : count_bit_seq_pkg
`default_nettype wire

// File: rtl/count_bit_byte.sv
`default_nettype none
// ============================================================================
// Module      : count_bit_byte
// Description : Combinational leading-bit counter for one byte. Counts how
//               many consecutive bits, starting at bit 7, equal i_bit_sel
//               (1 = leading ones, 0 = leading zeros). Result 0..8.
// Revision    : 1.0 - initial release
// ============================================================================
module count_bit_byte
    import count_bit_seq_pkg::*;
(
    input  logic [7:0]            i_byte,
    input  logic                  i_bit_sel,
    output logic [BYTE_CNT_W-1:0] o_count
);

    logic w_run;

    // Walk from the MSB down, counting until the first bit that differs
    always_comb begin
        o_count = '0;
        w_run   = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (w_run && (i_byte[i] == i_bit_sel)) begin
                o_count = o_count + BYTE_CNT_W'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

endmodule : count_bit_byte
`default_nettype wire

// File: rtl/count_bit_seq.sv
`default_nettype none
// ============================================================================
// Module      : count_bit_seq
// Description : Shared sequential CLO/CLZ unit for NREQ issue pipes. A
//               round-robin arbiter accepts one operand at a time; a single
//               byte scanner walks the operand MSB byte first and accumulates
//               the leading-bit count, which is returned with the owner id.
//               Build option COUNT_BIT_SEQ_EARLY_EXIT_EN: when defined the
//               scan stops on the first non-full byte; otherwise the scan
//               always takes four cycles and accumulation freezes instead.
// Revision    : 1.0 - initial release
// ============================================================================
module count_bit_seq
    import count_bit_seq_pkg::*;
#(
    parameter  int NREQ = 2,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_bit_sel,
    input  logic [NREQ-1:0][31:0]  req_val,
    output logic [NREQ-1:0]        req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [31:0]            resp_count,
    output logic                   busy
);

    state_t                r_state;
    state_t                w_next_state;
    logic [IDW-1:0]        r_last;
    logic [31:0]           r_operand;
    logic                  r_mode;
    logic [IDW-1:0]        r_id;
    logic [COUNT_W-1:0]    r_acc;
    logic [1:0]            r_byte_idx;
    logic                  r_frozen;

    logic                  w_grant_vld;
    logic [IDW-1:0]        w_grant_idx;
    logic [IDW-1:0]        w_cand;
    logic                  w_accept;
    logic [7:0]            w_byte;
    logic [BYTE_CNT_W-1:0] w_byte_cnt;
    logic                  w_byte_full;
    logic                  w_scan_last;

    // Round-robin pick: first requesting pipe after the last granted one
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_cand = IDW'((int'(r_last) + i) % NREQ);
            if (!w_grant_vld && req_valid[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    // Only an idle, unflushed controller may take a new operand
    assign w_accept = (r_state == ST_IDLE) && !flush && w_grant_vld;

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_ready
            assign req_ready[g] = w_accept && resetn && (w_grant_idx == IDW'(g));
        end
    endgenerate

    // Shared scanner, fed with the currently selected operand byte
    assign w_byte = r_operand[{r_byte_idx, 3'b000} +: 8];

    count_bit_byte u_count_bit_byte (
        .i_byte    (w_byte),
        .i_bit_sel (r_mode),
        .o_count   (w_byte_cnt)
    );

    assign w_byte_full = (w_byte_cnt == BYTE_CNT_W'(8));

`ifdef COUNT_BIT_SEQ_EARLY_EXIT_EN
    assign w_scan_last = !w_byte_full || (r_byte_idx == 2'd0);
`else
    assign w_scan_last = (r_byte_idx == 2'd0);
`endif

    // Controller state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides completion and response handshake
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)               w_next_state = ST_SCAN;
            ST_SCAN: if (flush)                  w_next_state = ST_IDLE;
                     else if (w_scan_last)       w_next_state = ST_DONE;
            ST_DONE: if (flush || resp_ready)    w_next_state = ST_IDLE;
            default:                             w_next_state = ST_IDLE;
        endcase
    end

    // Operand capture, arbitration pointer and per-byte accumulation
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last     <= IDW'(NREQ - 1);
            r_operand  <= '0;
            r_mode     <= 1'b0;
            r_id       <= '0;
            r_acc      <= '0;
            r_byte_idx <= 2'd3;
            r_frozen   <= 1'b0;
        end else if (w_accept) begin
            r_last     <= w_grant_idx;
            r_operand  <= req_val[w_grant_idx];
            r_mode     <= req_bit_sel[w_grant_idx];
            r_id       <= w_grant_idx;
            r_acc      <= '0;
            r_byte_idx <= 2'd3;
            r_frozen   <= 1'b0;
        end else if ((r_state == ST_SCAN) && !flush) begin
            if (!r_frozen) begin
                r_acc <= r_acc + COUNT_W'(w_byte_cnt);
            end
            if (!w_byte_full) begin
                r_frozen <= 1'b1;
            end
            if (!w_scan_last) begin
                r_byte_idx <= r_byte_idx - 2'd1;
            end
        end
    end

    assign resp_valid = (r_state == ST_DONE);
    assign resp_count = {{(32 - COUNT_W){1'b0}}, r_acc};
    assign resp_id    = r_id;
    assign busy       = (r_state != ST_IDLE);

endmodule : count_bit_seq
`default_nettype wire

// File: tb/tb_count_bit_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_count_bit_seq
// Description : Self-checking bench for count_bit_seq: directed corner
//               operands, randomized operands against a bit-level reference,
//               round-robin alternation, flush, back-pressure and mid-op reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_count_bit_seq;

    localparam int NREQ = 2;
    localparam int IDW  = 1;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 flush = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_bit_sel = '0;
    logic [NREQ-1:0][31:0] req_val = '0;
    logic [NREQ-1:0]      req_ready;
    logic                 resp_valid;
    logic                 resp_ready = 1'b0;
    logic [IDW-1:0]       resp_id;
    logic [31:0]          resp_count;
    logic                 busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int last_grant = NREQ - 1;

    count_bit_seq #(.NREQ(NREQ)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_bit_sel (req_bit_sel),
        .req_val     (req_val),
        .req_ready   (req_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_count  (resp_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: leading bits equal to mode, scanning the full word from bit 31
    function automatic int ref_count(input logic [31:0] v, input logic mode);
        int  n = 0;
        bit  run = 1'b1;
        for (int i = 31; i >= 0; i--) begin
            if (run && (v[i] == mode)) n++;
            else run = 1'b0;
        end
        return n;
    endfunction

    // Cycles from handshake cycle to first resp_valid cycle
    function automatic int exp_lat(input int c);
`ifdef COUNT_BIT_SEQ_EARLY_EXIT_EN
        return (c / 8 + 2 > 5) ? 5 : c / 8 + 2;
`else
        return 5;
`endif
    endfunction

    // Single-pipe operation, checked for grant, latency, count, id and return to idle
    task automatic do_op(input int pipe, input logic mode, input logic [31:0] val, input string tag);
        int exp_c;
        int lat;
        bit got;
        exp_c = ref_count(val, mode);
        req_valid = '0;
        req_valid[pipe] = 1'b1;
        req_bit_sel[pipe] = mode;
        req_val[pipe] = val;
        #1;
        n_cmp++;
        if (req_ready !== (NREQ'(1) << pipe)) begin
            n_fail++;
            $display("FAIL %s grant: got %b expected %b", tag, req_ready, NREQ'(1) << pipe);
        end
        step();
        req_valid = '0;
        last_grant = pipe;
        lat = 1;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (resp_valid === 1'b1) got = 1'b1;
            else begin
                step();
                lat++;
            end
        end
        n_cmp++;
        if (!got || lat != exp_lat(exp_c)) begin
            n_fail++;
            $display("FAIL %s latency: got %0d (seen=%0d) expected %0d", tag, lat, got, exp_lat(exp_c));
        end
        n_cmp++;
        if (resp_count !== 32'(exp_c)) begin
            n_fail++;
            $display("FAIL %s count: got %0d expected %0d", tag, resp_count, exp_c);
        end
        n_cmp++;
        if (resp_id !== IDW'(pipe)) begin
            n_fail++;
            $display("FAIL %s id: got %0d expected %0d", tag, resp_id, pipe);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle: busy=%b resp_valid=%b expected 0 0", tag, busy, resp_valid);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_valid = 2'b11;
        step();
        step();
        n_cmp++;
        if (req_ready !== 2'b00 || resp_valid !== 1'b0 || busy !== 1'b0 || resp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: req_ready=%b resp_valid=%b busy=%b resp_id=%0d expected 00 0 0 0",
                     req_ready, resp_valid, busy, resp_id);
        end
        resetn = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_rr_first: got %b expected 01", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    task automatic test_directed();
        do_op(0, 1'b0, 32'h8000_0000, "clz_msb");
        do_op(1, 1'b0, 32'h0000_0001, "clz_lsb");
        do_op(1, 1'b1, 32'hFFFF_FFFF, "clo_all");
        do_op(0, 1'b0, 32'h0000_0000, "clz_zero");
        do_op(0, 1'b1, 32'h0000_0000, "clo_zero");
        do_op(1, 1'b1, 32'hFFFF_FF7F, "clo_24");
    endtask

    task automatic test_random();
        int          pipe;
        logic        mode;
        int          sh;
        logic [31:0] v;
        for (int n = 0; n < 24; n++) begin
            pipe = $urandom_range(0, NREQ - 1);
            mode = 1'($urandom_range(0, 1));
            sh   = $urandom_range(0, 32);
            v    = $urandom;
            v    = (sh == 32) ? 32'h0 : (v >> sh);
            if (mode) v = ~v;
            do_op(pipe, mode, v, "random");
        end
    endtask

    task automatic test_round_robin();
        int exp_next;
        int owner;
        int resps;
        owner = 0;
        resps = 0;
        exp_next = (last_grant + 1) % NREQ;
        req_bit_sel = 2'b11;
        req_val[0] = 32'hF000_0000;
        req_val[1] = 32'hF000_0000;
        req_valid = 2'b11;
        resp_ready = 1'b1;
        #1;
        for (int c = 0; c < 80 && resps < 4; c++) begin
            if (resp_valid === 1'b1) begin
                n_cmp++;
                if (resp_count !== 32'd4 || resp_id !== IDW'(owner)) begin
                    n_fail++;
                    $display("FAIL rr_result: count=%0d id=%0d expected 4 %0d", resp_count, resp_id, owner);
                end
                resps++;
            end
            if (req_ready !== '0) begin
                n_cmp++;
                if (req_ready !== (NREQ'(1) << exp_next)) begin
                    n_fail++;
                    $display("FAIL rr_grant: got %b expected %b", req_ready, NREQ'(1) << exp_next);
                end
                owner = exp_next;
                last_grant = exp_next;
                exp_next = (exp_next + 1) % NREQ;
            end
            @(posedge clk);
            #2;
        end
        req_valid = '0;
        resp_ready = 1'b0;
        n_cmp++;
        if (resps != 4) begin
            n_fail++;
            $display("FAIL rr_timeout: responses %0d expected 4", resps);
        end
    endtask

    task automatic test_flush();
        bit seen;
        req_valid = 2'b01;
        req_bit_sel = 2'b00;
        req_val[0] = 32'h0000_00FF;
        flush = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL flush_idle_ready: got %b expected 00", req_ready);
        end
        step();
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle_busy: got %b expected 0", busy);
        end
        #1;
        step();
        req_valid = '0;
        last_grant = 0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_scan: busy=%b resp_valid=%b expected 0 0", busy, resp_valid);
        end
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (resp_valid === 1'b1) seen = 1'b1;
            step();
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_no_resp: resp_valid seen=1 expected 0");
        end
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b10) begin
            n_fail++;
            $display("FAIL flush_rr_kept: got %b expected 10", req_ready);
        end
        req_valid = '0;
        do_op(1, 1'b0, 32'h0000_00FF, "after_flush");
    endtask

    task automatic test_backpressure();
        bit got;
        req_valid = 2'b01;
        req_bit_sel = 2'b01;
        req_val[0] = 32'hF000_0000;
        #1;
        step();
        req_valid = 2'b10;
        req_val[1] = 32'h1234_5678;
        last_grant = 0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            if (resp_valid === 1'b1) got = 1'b1;
            else step();
        end
        n_cmp++;
        if (!got) begin
            n_fail++;
            $display("FAIL bp_timeout: resp_valid never seen");
        end
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++;
            if (resp_valid !== 1'b1 || resp_count !== 32'd4 || resp_id !== 1'b0 || req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL bp_hold: valid=%b count=%0d id=%0d ready=%b expected 1 4 0 00",
                         resp_valid, resp_count, resp_id, req_ready);
            end
            step();
        end
        req_valid = '0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        req_valid = 2'b10;
        req_bit_sel = 2'b00;
        req_val[1] = 32'h0000_0001;
        #1;
        step();
        req_valid = '0;
        step();
        #1;
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0 || resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: busy=%b resp_valid=%b expected 0 0", busy, resp_valid);
        end
        step();
        resetn = 1'b1;
        last_grant = NREQ - 1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (resp_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
            step();
        end
        n_cmp++;
        if (seen) begin
            n_fail++;
            $display("FAIL reset_mid_no_resp: activity seen=1 expected 0");
        end
        req_valid = 2'b11;
        #1;
        n_cmp++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_rr: got %b expected 01", req_ready);
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_round_robin();
        test_flush();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_count_bit_seq
`default_nettype wire
